mul8_shift_add: RTL and testbench
=================================

MUL8_SHIFT_ADD -- requirements
Module: mul8_shift_add

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 The block SHALL have parameter N_STEP, default 8, meaning the number of shift-add iterations (always the operand width).
REQ-003 The block SHALL have parameter ACC_W, default 20, meaning the accumulator width in bits.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand request.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 in_a  input  8  unsigned multiplicand.
REQ-009 in_b  input  8  unsigned multiplier.
REQ-010 in_acc  input  1  1: add product to accumulator; 0: load product into accumulator.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 out_prod  output  16  unsigned product in_a*in_b.
REQ-014 out_acc  output  ACC_W  accumulator value.
REQ-015 acc_ovf  output  1  sticky accumulator carry-out flag.

Function
REQ-016 The block SHALL implement FSM states IDLE, BUSY, ACC and DONE.
REQ-017 in_ready SHALL equal (state==IDLE), decoded combinationally.
REQ-018 An input transfer SHALL occur on the edge where in_valid&&in_ready: latch in_a into M, in_b into Q, in_acc into a flag, clear {C,A_hi}, clear step count, then go to BUSY.
REQ-019 Each BUSY edge SHALL perform one step: sum={C,A_hi}+(Q[0]?M:0) via 8-bit adder, then {C,A_hi,Q} <= {sum,Q}>>1 (logical shift right, C into MSB).
REQ-020 After exactly 8 BUSY edges the FSM SHALL go to ACC, with product {A_hi,Q} final.
REQ-021 On the ACC edge, out_acc SHALL become flag ? out_acc+zero-extended product : zero-extended product (mod 2^ACC_W), and the FSM SHALL go to DONE.
REQ-022 On the ACC edge, acc_ovf SHALL be set when the accumulate add carries out of bit ACC_W-1, and SHALL be cleared when flag=0; it SHALL otherwise hold.
REQ-023 out_valid SHALL equal (state==DONE); first assertion is 10 cycles after the accept edge (1 accept + 8 BUSY + 1 ACC).
REQ-024 out_prod, out_acc and acc_ovf SHALL hold stable while out_valid&&!out_ready.
REQ-025 On the edge with out_valid&&out_ready the FSM SHALL go to IDLE; no same-cycle re-accept; minimum issue interval is 11 cycles.
REQ-026 in_valid in states other than IDLE SHALL be ignored, and operands SHALL not be sampled.
REQ-027 Operand 0 on either input SHALL still take the full 8 steps and give product 0; there is no early termination.
REQ-028 out_prod and out_acc SHALL hold their last values across IDLE.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE; out_valid=0, out_prod=0, out_acc=0, acc_ovf=0, and M, Q, A_hi, C and count to 0.
REQ-030 Reset asserted mid-BUSY or mid-ACC SHALL abort the operation with no accumulator update.
REQ-031 in_ready SHALL read 1 during and after reset.
REQ-032 Reset deassertion SHALL be synchronised externally.

Structure
REQ-033 Shared header mul8_defs.vh SHALL hold the state encodings (2-bit), N_STEP, ACC_W and the product width of 16.
REQ-034 The block SHALL instantiate sub-module fa8bit_sc once, as the step adder with Cin=0 and Cout driving C.
REQ-035 The accumulator add SHALL be behavioural.

Verification
REQ-036 Load: a=0xFF, b=0xFF, acc=0 -> out_valid at cycle 10; out_prod=0xFE01, out_acc=0x0FE01, acc_ovf=0.
REQ-037 Accumulate: then a=13, b=11, acc=1 -> out_prod=0x008F, out_acc=0x0FE90.
REQ-038 Overflow: 0xFF*0xFF load plus 16 accumulates -> after the 16th accumulate, out_acc=0x0DE11 and acc_ovf=1; a subsequent load (acc=0) clears acc_ovf.
REQ-039 Back-pressure: out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, and in_valid pulses are ignored; out_ready=1 -> IDLE next edge.
REQ-040 Reset mid-BUSY: rst_n low at step 4 of 0x12*0x34 -> all outputs 0 and IDLE; a following 0x12*0x34 load gives 0x03A8.
REQ-041 Zero: a=0x00, b=0xA5, acc=0 -> out_prod=0, latency still 10 cycles.

Source files
------------

// File: rtl/mul8_shift_add_pkg.sv
// Shared widths, FSM encodings and request payload for the shift-add multiplier.
package mul8_shift_add_pkg;

  localparam int unsigned OP_W       = 8;
  localparam int unsigned PROD_W     = 16;
  localparam int unsigned STATE_W    = 2;
  localparam int unsigned N_STEP_DEF = 8;
  localparam int unsigned ACC_W_DEF  = 20;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_BUSY = 2'd1;
  localparam logic [STATE_W-1:0] ST_ACC  = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic            acc;
  } mul_req_t;

  // Partial product for one step: multiplicand gated by the current multiplier LSB.
  function automatic logic [OP_W-1:0] step_addend(input logic [OP_W-1:0] m, input logic q0);
    return q0 ? m : '0;
  endfunction

endpackage

// File: rtl/mul8_shift_add_fa8bit_sc.sv
// 8-bit ripple-carry adder built from full-adder cells; used as the per-step adder.
module fa8bit_sc (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic carry;

  always_comb begin
    carry = cin;
    sum   = '0;
    for (int i = 0; i < 8; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/mul8_shift_add.sv
// Sequential 8x8 shift-add multiplier with optional accumulate into an ACC_W-bit register.
module mul8_shift_add
  import mul8_shift_add_pkg::*;
#(
  parameter int unsigned N_STEP = N_STEP_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic              in_acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_prod,
  output logic [ACC_W-1:0]  out_acc,
  output logic              acc_ovf
);

  localparam int unsigned CNT_W   = $clog2(N_STEP + 1);
  localparam int unsigned ACC_X_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_STEP - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [OP_W-1:0]    m_q, m_d;
  logic [OP_W-1:0]    q_q, q_d;
  logic [OP_W-1:0]    a_hi_q, a_hi_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               flag_q, flag_d;
  logic [PROD_W-1:0]  prod_q, prod_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;

  mul_req_t           req;
  logic [OP_W-1:0]    addend;
  logic [OP_W-1:0]    fa_sum;
  logic               fa_cout;
  logic               step_c;
  logic [PROD_W-1:0]  prod_final;
  logic [ACC_X_W-1:0] acc_sum;

  assign req        = '{a: in_a, b: in_b, acc: in_acc};
  assign addend     = step_addend(m_q, q_q[0]);
  assign prod_final = {a_hi_q, q_q};

  // C is always zero entering a step, so the 9-bit {C,A_hi} sum only needs the adder's carry.
  fa8bit_sc u_step_add (
    .a    (a_hi_q),
    .b    (addend),
    .cin  (1'b0),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign step_c  = c_q ^ fa_cout;
  assign acc_sum = {1'b0, acc_q} + ACC_X_W'(prod_final);

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    a_hi_d  = a_hi_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          m_d     = req.a;
          q_d     = req.b;
          flag_d  = req.acc;
          a_hi_d  = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        {c_d, a_hi_d, q_d} = {1'b0, step_c, fa_sum, q_q[OP_W-1:1]};
        if (cnt_q == LAST_STEP) begin
          state_d = ST_ACC;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACC: begin
        prod_d = prod_final;
        if (flag_q) begin
          acc_d = acc_sum[ACC_W-1:0];
          ovf_d = ovf_q | acc_sum[ACC_W];
        end else begin
          acc_d = ACC_W'(prod_final);
          ovf_d = 1'b0;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      q_q     <= '0;
      a_hi_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      prod_q  <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      a_hi_q  <= a_hi_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_prod  = prod_q;
  assign out_acc   = acc_q;
  assign acc_ovf   = ovf_q;

endmodule

// File: tb/tb_mul8_shift_add.sv
// Self-checking bench for mul8_shift_add: directed vectors, corner sequences and random traffic.
module tb_mul8_shift_add;

  localparam int unsigned ACC_W = 20;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_acc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_prod;
  logic [19:0] out_acc;
  logic        acc_ovf;

  int n_total = 0;
  int n_pass  = 0;

  int unsigned acc_m = 0;
  bit          ovf_m = 1'b0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        acc;
    logic [15:0] prod;
    logic [19:0] accv;
    logic        ovf;
  } vec_t;

  vec_t vecs[5];

  mul8_shift_add #(.N_STEP(8), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_acc    (in_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_acc   (out_acc),
    .acc_ovf   (acc_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  // Reference: exact product, then load or accumulate modulo 2^ACC_W with sticky carry.
  task automatic model_apply(input logic [7:0] a, input logic [7:0] b, input logic accen,
                             output logic [15:0] p, output logic [19:0] av, output logic ov);
    int unsigned pi;
    longint unsigned s;
    pi = {24'd0, a} * {24'd0, b};
    if (accen) begin
      s = longint'(acc_m) + longint'(pi);
      if (s >= (64'd1 << ACC_W)) ovf_m = 1'b1;
      acc_m = 32'(s % (64'd1 << ACC_W));
    end else begin
      acc_m = pi;
      ovf_m = 1'b0;
    end
    p  = 16'(pi);
    av = 20'(acc_m);
    ov = ovf_m;
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic accen,
                         input int hold, input bit noise,
                         input logic [15:0] ep, input logic [19:0] ea, input logic eo);
    int lat;
    in_a = a; in_b = b; in_acc = accen; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_a = 8'($urandom); in_b = 8'($urandom); in_acc = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(lat), 32'd10);
    chk("out_prod", 32'(out_prod), 32'(ep));
    chk("out_acc", 32'(out_acc), 32'(ea));
    chk("acc_ovf", 32'(acc_ovf), 32'(eo));
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_a = 8'($urandom); in_b = 8'($urandom); in_acc = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_prod", 32'(out_prod), 32'(ep));
      chk("hold_acc", 32'(out_acc), 32'(ea));
      chk("hold_ovf", 32'(acc_ovf), 32'(eo));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic model_txn(input logic [7:0] a, input logic [7:0] b, input logic accen,
                           input int hold, input bit noise);
    logic [15:0] p;
    logic [19:0] av;
    logic        ov;
    model_apply(a, b, accen, p, av, ov);
    run_txn(a, b, accen, hold, noise, p, av, ov);
  endtask

  initial begin
    logic [15:0] p;
    logic [19:0] av;
    logic        ov;

    vecs[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, 20'h0FE01, 1'b0};
    vecs[1] = '{8'd13, 8'd11, 1'b1, 16'h008F, 20'h0FE90, 1'b0};
    vecs[2] = '{8'h00, 8'hA5, 1'b0, 16'h0000, 20'h00000, 1'b0};
    vecs[3] = '{8'h12, 8'h34, 1'b0, 16'h03A8, 20'h003A8, 1'b0};
    vecs[4] = '{8'hFF, 8'h01, 1'b1, 16'h00FF, 20'h004A7, 1'b0};

    in_valid = 1'b0; in_a = '0; in_b = '0; in_acc = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_prod", 32'(out_prod), 32'd0);
    chk("rst_acc", 32'(out_acc), 32'd0);
    chk("rst_ovf", 32'(acc_ovf), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 5; i++) begin
      model_apply(vecs[i].a, vecs[i].b, vecs[i].acc, p, av, ov);
      run_txn(vecs[i].a, vecs[i].b, vecs[i].acc, 0, 1'b0, vecs[i].prod, vecs[i].accv, vecs[i].ovf);
    end

    // Back-pressure with ignored in_valid pulses during BUSY and DONE.
    model_txn(8'h5A, 8'h3C, 1'b1, 5, 1'b1);

    // Overflow: one load of 0xFF*0xFF then 16 accumulates of the same product.
    model_txn(8'hFF, 8'hFF, 1'b0, 0, 1'b0);
    for (int i = 0; i < 16; i++) model_txn(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    chk("ovf_seq_acc", 32'(out_acc), 32'h0DE11);
    chk("ovf_seq_flag", 32'(acc_ovf), 32'd1);
    model_txn(8'd2, 8'd3, 1'b0, 0, 1'b0);
    chk("load_clears_ovf", 32'(acc_ovf), 32'd0);

    // Reset after four BUSY steps must abort with everything cleared.
    in_a = 8'h12; in_b = 8'h34; in_acc = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_prod", 32'(out_prod), 32'd0);
    chk("abort_acc", 32'(out_acc), 32'd0);
    chk("abort_ovf", 32'(acc_ovf), 32'd0);
    acc_m = 0; ovf_m = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(8'h12, 8'h34, 1'b0, 0, 1'b0, 16'h03A8, 20'h003A8, 1'b0);
    acc_m = 32'h3A8;

    // Random traffic, biased toward accumulation so the sticky carry gets exercised.
    for (int i = 0; i < 40; i++) begin
      model_txn(8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
